// File: rtl/comparator_pkg.sv
// Shared encodings for the sequential magnitude comparator.
package comparator_pkg;

  // Controller states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  // Outcome of a comparison before it is loaded into the result flags.
  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } result_t;

endpackage

// File: rtl/slice_compare.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
module slice_compare #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             eq,
  output logic             gt
);

  // Equality and unsigned greater-than of the selected slice.
  always_comb begin
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/magnitude_comparator_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator, SLICE bits per clock, MSB slice first.
// Optional macro COMP_EARLY_EXIT_EN: finish at the first differing slice instead of
// always walking down to slice 0.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; results hold their last value
//   ST_CMP  | comparing slice idx of the latched operands, one per clock
module magnitude_comparator_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             less
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  sh_a;
  logic [WIDTH-1:0]  sh_b;
  logic [WIDTH-1:0]  flip;
  logic [IDXW-1:0]   idx;
  logic [SLICE-1:0]  sl_a;
  logic [SLICE-1:0]  sl_b;
  logic              sl_eq;
  logic              sl_gt;
  logic              resolved;
  logic              res_gt_q;
  logic              accept;
  logic              finish;
  result_t           res_cur;

  // Signed operands become offset-binary so a plain unsigned compare orders them.
  assign flip = signed_mode ? MSB_MASK : '0;
  assign busy = (state == ST_CMP);

  // Select the slice under comparison from the latched operands.
  always_comb begin
    sh_a = op_a >> (SLICE * int'(idx));
    sh_b = op_b >> (SLICE * int'(idx));
    sl_a = sh_a[SLICE-1:0];
    sl_b = sh_b[SLICE-1:0];
  end

  slice_compare #(.SLICE(SLICE)) u_slice_compare (
    .a  (sl_a),
    .b  (sl_b),
    .eq (sl_eq),
    .gt (sl_gt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: accept start in IDLE, decide when CMP completes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_CMP;
        end
      end
      ST_CMP: begin
`ifdef COMP_EARLY_EXIT_EN
        finish = (idx == '0) || !sl_eq;
`else
        finish = (idx == '0);
`endif
        if (finish) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outcome so far: an earlier mismatch wins over the current slice.
  always_comb begin
    res_cur = RES_EQ;
    if (resolved)    res_cur = res_gt_q ? RES_GT : RES_LT;
    else if (!sl_eq) res_cur = sl_gt ? RES_GT : RES_LT;
  end

  // Operand latch, slice walk, sticky mismatch capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      idx      <= '0;
      resolved <= 1'b0;
      res_gt_q <= 1'b0;
      done     <= 1'b0;
      equal    <= 1'b0;
      greater  <= 1'b0;
      less     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a     <= a ^ flip;
        op_b     <= b ^ flip;
        idx      <= IDX_TOP;
        resolved <= 1'b0;
        res_gt_q <= 1'b0;
      end else if (state == ST_CMP) begin
        if (!resolved && !sl_eq) begin
          resolved <= 1'b1;
          res_gt_q <= sl_gt;
        end
        if (finish) begin
          done    <= 1'b1;
          equal   <= (res_cur == RES_EQ);
          greater <= (res_cur == RES_GT);
          less    <= (res_cur == RES_LT);
        end else begin
          idx <= idx - 1'b1;
        end
      end
    end
  end

endmodule
